// File: rtl/router_pkt_ctrl.sv
// Ingress controller for the 1x3 router: decodes the header, steers bytes into one
// destination FIFO, throttles the source with busy and checks parity and length.
//
// state       | meaning
// ------------+------------------------------------------------------------
// DECODE      | idle, waiting for a header byte
// WAIT_EMPTY  | header latched, waiting for the destination FIFO to drain
// LOAD_FIRST  | writing the latched header
// LOAD_DATA   | streaming payload, catching the parity byte
// FULL        | destination full, one payload byte parked in hold
// AFTER_FULL  | writing the parked byte once space returns
// LOAD_PARITY | writing the received parity byte
// CHECK       | comparing parity and payload count, updating err
// DROP        | discarding a packet until its parity byte
module router_pkt_ctrl #(
   parameter int DATA_W   = 8,
   parameter int NUM_DEST = 3
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                pkt_valid,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [NUM_DEST-1:0] fifo_full,
   input  logic [NUM_DEST-1:0] fifo_empty,
   input  logic [NUM_DEST-1:0] soft_reset,
   output logic [DATA_W-1:0]   fifo_wdata,
   output logic [NUM_DEST-1:0] write_enb,
   output logic                busy,
   output logic                err
);

   localparam logic [3:0] S_DECODE      = 4'd0;
   localparam logic [3:0] S_WAIT_EMPTY  = 4'd1;
   localparam logic [3:0] S_LOAD_FIRST  = 4'd2;
   localparam logic [3:0] S_LOAD_DATA   = 4'd3;
   localparam logic [3:0] S_FULL        = 4'd4;
   localparam logic [3:0] S_AFTER_FULL  = 4'd5;
   localparam logic [3:0] S_LOAD_PARITY = 4'd6;
   localparam logic [3:0] S_CHECK       = 4'd7;
   localparam logic [3:0] S_DROP        = 4'd8;

   localparam logic [1:0] ADDR_LIM = 2'(NUM_DEST);

   logic [3:0]        state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [1:0]        addr_q, addr_d;
   logic [5:0]        len_q, len_d;
   logic [DATA_W-1:0] parity_q, parity_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [1:0]          hdr_addr;
   logic [5:0]          hdr_len;
   logic [NUM_DEST-1:0] hdr_oh, dest_oh;
   logic                hdr_empty, dst_full, dst_empty, dst_srst;
   logic [5:0]          cnt_inc;
   logic                wr, use_in;

   assign hdr_addr  = data_in[1:0];
   assign hdr_len   = data_in[7:2];
   assign hdr_oh    = NUM_DEST'(1) << hdr_addr;
   assign dest_oh   = NUM_DEST'(1) << addr_q;
   assign hdr_empty = |(fifo_empty & hdr_oh);
   assign dst_full  = |(fifo_full & dest_oh);
   assign dst_empty = |(fifo_empty & dest_oh);
   assign dst_srst  = |(soft_reset & dest_oh);
   assign cnt_inc   = (cnt_q == 6'h3f) ? cnt_q : cnt_q + 6'd1;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      addr_d   = addr_q;
      len_d    = len_q;
      parity_d = parity_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      wr       = 1'b0;
      use_in   = 1'b0;
      case (state_q)
         S_DECODE: begin
            if (pkt_valid) begin
               if (hdr_addr < ADDR_LIM) begin
                  hold_d   = data_in;
                  addr_d   = hdr_addr;
                  len_d    = hdr_len;
                  parity_d = data_in;
                  cnt_d    = 6'd0;
                  err_d    = 1'b0;
                  state_d  = hdr_empty ? S_LOAD_FIRST : S_WAIT_EMPTY;
               end else begin
                  state_d = S_DROP;
               end
            end
         end
         S_WAIT_EMPTY: if (dst_empty) state_d = S_LOAD_FIRST;
         // A full destination never takes a write; the header simply waits here.
         S_LOAD_FIRST: begin
            if (!dst_full) begin
               wr      = 1'b1;
               state_d = S_LOAD_DATA;
            end
         end
         S_LOAD_DATA: begin
            if (pkt_valid) begin
               if (!dst_full) begin
                  wr       = 1'b1;
                  use_in   = 1'b1;
                  parity_d = parity_q ^ data_in;
                  cnt_d    = cnt_inc;
               end else begin
                  hold_d  = data_in;
                  state_d = S_FULL;
               end
            end else begin
               hold_d  = data_in;
               state_d = S_LOAD_PARITY;
            end
         end
         S_FULL: if (!dst_full) state_d = S_AFTER_FULL;
         S_AFTER_FULL: begin
            if (!dst_full) begin
               wr       = 1'b1;
               parity_d = parity_q ^ hold_q;
               cnt_d    = cnt_inc;
               state_d  = S_LOAD_DATA;
            end
         end
         S_LOAD_PARITY: begin
            if (!dst_full) begin
               wr      = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            err_d   = (parity_q != hold_q) || (cnt_q != len_q);
            state_d = S_DECODE;
         end
         S_DROP: if (!pkt_valid) state_d = S_DECODE;
         default: state_d = S_DECODE;
      endcase

      // Destination abort overrides whatever the packet was doing this cycle.
      if (dst_srst && (state_q != S_DECODE) && (state_q != S_DROP) && (state_q != S_CHECK)) begin
         wr       = 1'b0;
         use_in   = 1'b0;
         hold_d   = hold_q;
         parity_d = parity_q;
         cnt_d    = cnt_q;
         err_d    = err_q;
         state_d  = pkt_valid ? S_DROP : S_DECODE;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_DECODE;
         hold_q   <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         parity_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         parity_q <= parity_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign write_enb  = wr ? dest_oh : '0;
   assign fifo_wdata = use_in ? data_in : hold_q;
   assign err        = err_q;
   assign busy       = (state_q == S_WAIT_EMPTY) || (state_q == S_LOAD_FIRST) ||
                       (state_q == S_FULL) || (state_q == S_AFTER_FULL) ||
                       (state_q == S_LOAD_PARITY) || (state_q == S_CHECK);

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Scoreboard bench for router_pkt_ctrl: directed packet scenarios followed by
// randomized packets under random FIFO full/empty back-pressure.
module tb_router_pkt_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full, fifo_empty, soft_reset;
   logic [7:0] fifo_wdata;
   logic [2:0] write_enb;
   logic       busy, err;

   router_pkt_ctrl #(.DATA_W(8), .NUM_DEST(3)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .pkt_valid  (pkt_valid),
      .data_in    (data_in),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .soft_reset (soft_reset),
      .fifo_wdata (fifo_wdata),
      .write_enb  (write_enb),
      .busy       (busy),
      .err        (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] dest;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;
   int  wr_count = 0;
   bit  model_err = 1'b0;
   bit  rand_env = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int addr, input logic [7:0] d);
      wr_t e;
      e.dest = 3'b001 << addr;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every FIFO write must match the head of the expected queue.
   always @(negedge clock) begin
      if (resetn === 1'b1 && write_enb !== 3'b000) begin
         wr_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: write_enb=%b data=%h, expected no write", write_enb, fifo_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_dest", {29'd0, write_enb}, {29'd0, mon_e.dest});
            check("write_data", {24'd0, fifo_wdata}, {24'd0, mon_e.data});
         end
      end
   end

   always @(posedge clock) begin
      if (rand_env) begin
         #2;
         for (int i = 0; i < 3; i++) begin
            fifo_full[i]  = ($urandom_range(0, 3) == 0);
            fifo_empty[i] = ($urandom_range(0, 9) < 6);
         end
      end
   end

   // All driving tasks return 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] d, input logic v);
      bit ok = 1'b0;
      int n = 0;
      data_in   = d;
      pkt_valid = v;
      while (!ok && n < 200) begin
         @(negedge clock);
         ok = !busy;
         @(posedge clock);
         n++;
      end
      #1;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: byte %h not consumed, busy stuck at 1 for 200 cycles", d);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      int n = 0;
      pkt_valid = 1'b0;
      while (!ok && n < 200) begin
         @(negedge clock);
         ok = !busy;
         @(posedge clock);
         n++;
      end
      #1;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy still 1 after 200 cycles, expected 0");
      end
   endtask

   task automatic send_body(input int addr, input int len, input int npay,
                            input logic [7:0] corrupt, input logic [7:0] hdr);
      logic [7:0] par;
      logic [7:0] b;
      bit valid = (addr < 3);
      par = hdr;
      for (int i = 0; i < npay; i++) begin
         b = 8'($urandom_range(0, 255));
         par ^= b;
         if (valid) push(addr, b);
         send_byte(b, 1'b1);
         if (!valid) check("drop_busy", {31'd0, busy}, 32'd0);
      end
      if (valid) push(addr, par ^ corrupt);
      send_byte(par ^ corrupt, 1'b0);
      if (valid) model_err = (corrupt != 8'h00) || (npay != len);
      wait_idle();
      check("err_after_packet", {31'd0, err}, {31'd0, model_err});
   endtask

   task automatic send_packet(input int addr, input int len, input int npay, input logic [7:0] corrupt);
      logic [7:0] hdr;
      hdr = {len[5:0], addr[1:0]};
      if (addr < 3) push(addr, hdr);
      send_byte(hdr, 1'b1);
      if (addr < 3) begin
         model_err = 1'b0;
         check("err_clear_on_header", {31'd0, err}, 32'd0);
      end else begin
         check("drop_busy", {31'd0, busy}, 32'd0);
      end
      send_body(addr, len, npay, corrupt, hdr);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete, errors so far %0d", errors);
      $fatal(1, "global timeout");
   end

   initial begin
      int base;
      int a, l, np;
      logic [7:0] hdr, b, par, cor;

      resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
      fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
      repeat (2) @(posedge clock);
      #1;
      check("reset_write_enb", {29'd0, write_enb}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_wdata", {24'd0, fifo_wdata}, 32'd0);
      resetn = 1'b1;
      @(posedge clock); #1;

      // Good packet, then the same packet with a corrupted parity byte.
      base = wr_count;
      send_packet(1, 3, 3, 8'h00);
      check("t1_write_count", wr_count - base, 5);
      base = wr_count;
      send_packet(1, 3, 3, 8'h01);
      check("t2_write_count", wr_count - base, 5);

      // Destination not empty: header waits under busy.
      fifo_empty = 3'b110;
      hdr = {6'd2, 2'd0};
      push(0, hdr);
      send_byte(hdr, 1'b1);
      model_err = 1'b0;
      check("t3_err_cleared", {31'd0, err}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("t3_busy_wait", {31'd0, busy}, 32'd1);
         check("t3_no_write", {29'd0, write_enb}, 32'd0);
         @(posedge clock); #1;
      end
      fifo_empty = 3'b111;
      send_body(0, 2, 2, 8'h00, hdr);

      // Destination full mid-payload: byte parked and written exactly once.
      base = wr_count;
      hdr = {6'd4, 2'd2};
      par = hdr;
      push(2, hdr);
      send_byte(hdr, 1'b1);
      b = 8'hA5; par ^= b; push(2, b); send_byte(b, 1'b1);
      fifo_full = 3'b100;
      b = 8'h3C; par ^= b; push(2, b); send_byte(b, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("t4_busy_full", {31'd0, busy}, 32'd1);
         check("t4_no_write", {29'd0, write_enb}, 32'd0);
         @(posedge clock); #1;
      end
      fifo_full = 3'b000;
      b = 8'h5A; par ^= b; push(2, b); send_byte(b, 1'b1);
      b = 8'hC3; par ^= b; push(2, b); send_byte(b, 1'b1);
      push(2, par); send_byte(par, 1'b0);
      wait_idle();
      check("t4_err", {31'd0, err}, 32'd0);
      check("t4_write_count", wr_count - base, 6);

      // Invalid address is dropped.
      base = wr_count;
      send_packet(3, 2, 2, 8'h00);
      check("t5_write_count", wr_count - base, 0);

      // Soft reset mid-payload, then a clean packet to another port.
      base = wr_count;
      hdr = {6'd5, 2'd1};
      push(1, hdr);
      send_byte(hdr, 1'b1);
      model_err = 1'b0;
      b = 8'h11; push(1, b); send_byte(b, 1'b1);
      b = 8'h22; push(1, b); send_byte(b, 1'b1);
      soft_reset = 3'b010;
      send_byte(8'h33, 1'b1);
      soft_reset = 3'b000;
      check("t6_drop_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b0);
      wait_idle();
      check("t6_err", {31'd0, err}, 32'd0);
      check("t6_write_count", wr_count - base, 3);
      send_packet(0, 2, 2, 8'h00);

      // Async reset while dropping with err set, and while mid-packet.
      send_packet(1, 2, 2, 8'h80);
      send_byte({6'd3, 2'd3}, 1'b1);
      send_byte(8'h77, 1'b1);
      check("rst_err_before", {31'd0, err}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      pkt_valid = 1'b0;
      model_err = 1'b0;
      @(posedge clock); #1 resetn = 1'b1;
      @(posedge clock); #1;
      hdr = {6'd3, 2'd2};
      push(2, hdr); send_byte(hdr, 1'b1);
      b = 8'h9E; push(2, b); send_byte(b, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("rst_mid_write_enb", {29'd0, write_enb}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_wdata", {24'd0, fifo_wdata}, 32'd0);
      check("rst_mid_pending", exp_q.size(), 0);
      pkt_valid = 1'b0;
      @(posedge clock); #1 resetn = 1'b1;
      @(posedge clock); #1;
      send_packet(2, 3, 3, 8'h00);

      // Randomized packets under random back-pressure.
      rand_env = 1'b1;
      for (int k = 0; k < 40; k++) begin
         a  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         l  = int'($urandom_range(0, 15));
         np = l;
         if ($urandom_range(0, 5) == 0) np = (l > 0 && $urandom_range(0, 1) == 1) ? l - 1 : l + 1;
         cor = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         send_packet(a, l, np, cor);
      end
      rand_env = 1'b0;
      @(posedge clock); #3;
      fifo_full = 3'b000; fifo_empty = 3'b111;
      repeat (4) @(posedge clock);
      #1;
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
